// File: rtl/img_pingpong_buf.sv
// img_pingpong_buf: two-bank frame buffer, sequential fill on one bank while the other is randomly read
module img_pingpong_buf #(
    parameter int DATA_W = 16,
    parameter int DEPTH = 784,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_flush,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_data_valid,
    output logic              rd_oor,
    output logic              rd_avail,
    input  logic              rd_release,
    output logic [1:0]        frames_ready
);
    localparam int MEM_AW = $clog2(2 * DEPTH);
    localparam logic [MEM_AW-1:0] BANK_OFS = MEM_AW'(DEPTH);

    logic [DATA_W-1:0] mem [0:2*DEPTH-1];
    logic              wr_bank, rd_bank;
    logic [ADDR_W-1:0] wr_cnt;
    logic [1:0]        full, full_nxt;
    logic              wr_fire, wr_last, rel, rd_fire, in_range;
    logic [MEM_AW-1:0] wr_idx, rd_idx;

    assign wr_ready     = !full[wr_bank];
    assign rd_avail     = full[rd_bank];
    assign frames_ready = {1'b0, full[0]} + {1'b0, full[1]};
    assign wr_fire      = wr_valid && wr_ready && !wr_flush;
    assign wr_last      = wr_cnt == ADDR_W'(DEPTH - 1);
    assign rel          = rd_release && rd_avail;
    assign rd_fire      = rd_req && rd_avail;
    assign in_range     = 32'(rd_addr) < DEPTH;
    assign wr_idx       = (wr_bank ? BANK_OFS : '0) + MEM_AW'(wr_cnt);
    assign rd_idx       = (rd_bank ? BANK_OFS : '0) + MEM_AW'(rd_addr);

    // a completing write and a release never target the same bank, so set/clear compose freely
    always_comb begin
        full_nxt = full;
        full_nxt = full_nxt | ((wr_fire && wr_last) ? (wr_bank ? 2'b10 : 2'b01) : 2'b00);
        full_nxt = full_nxt & ~(rel ? (rd_bank ? 2'b10 : 2'b01) : 2'b00);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            wr_cnt  <= '0;
            full    <= 2'b00;
        end else begin
            full <= full_nxt;
            if (rel)
                rd_bank <= !rd_bank;
            if (wr_flush)
                wr_cnt <= '0;
            else if (wr_fire) begin
                wr_cnt <= wr_last ? '0 : wr_cnt + 1'b1;
                if (wr_last)
                    wr_bank <= !wr_bank;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_fire)
            mem[wr_idx] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data       <= '0;
            rd_data_valid <= 1'b0;
            rd_oor        <= 1'b0;
        end else begin
            rd_data_valid <= rd_fire;
            rd_oor        <= rd_fire && !in_range;
            if (rd_fire)
                rd_data <= in_range ? mem[rd_idx] : '0;
        end
    end
endmodule
